minc_prog_loader: RTL



---
 rtl/minc_prog_loader_if.sv | 14 +
 rtl/minc_prog_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minc_prog_loader_if.sv
// minc_prog_loader_if
// Instruction-memory write port driven by the program loader.
//   rom_we    : one-cycle write strobe
//   rom_addr  : 8-bit word address
//   rom_wdata : 15-bit instruction word
// Modports: master (loader, drives the port), slave (memory, receives it).
interface minc_prog_loader_if;
    logic        rom_we;
    logic [7:0]  rom_addr;
    logic [14:0] rom_wdata;

    modport master (output rom_we, output rom_addr, output rom_wdata);
    modport slave  (input  rom_we, input  rom_addr, input  rom_wdata);
endinterface

// File: rtl/minc_prog_loader.sv
// minc_prog_loader
// Receives a framed 8N1 UART byte stream, assembles 15-bit instruction words
// and writes them sequentially from address 0 into the minc instruction
// memory. The core is held in reset while a frame is loading and is released
// only after the frame checksum matches.
// Frame: A5, N (0 = 256 words), N x {lo, hi}, checksum (8-bit sum of N and data).
// Ports:
//   CLK, RESET   : system clock, synchronous active-high reset
//   RXD          : asynchronous UART line, idle high
//   rom          : instruction-memory write port (master side)
//   cpu_nreset   : core reset, active-low
//   busy         : a frame is in progress
//   done         : one-cycle pulse on a successful load
//   err          : sticky error, cleared by the next sync byte or RESET
module minc_prog_loader #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       RXD,
    minc_prog_loader_if.master         rom,
    output logic                       cpu_nreset,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {F_SYNC, F_COUNT, F_LO, F_HI, F_CSUM, F_ERR} fr_state_t;

    // ---------------- RXD synchronizer ----------------
    logic rxd_meta_q, rxd_meta_d;
    logic rxd_sync_q, rxd_sync_d;
    logic rxd_prev_q, rxd_prev_d;
    logic rxd_fall;

    // Next-state for the two-flop synchronizer and the edge-detect history
    always_comb begin
        rxd_meta_d = RXD;
        rxd_sync_d = rxd_meta_q;
        rxd_prev_d = rxd_sync_q;
        rxd_fall   = rxd_prev_q & ~rxd_sync_q;
    end

    // Synchronizer flops; idle line level is high
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_meta_d;
            rxd_sync_q <= rxd_sync_d;
            rxd_prev_q <= rxd_prev_d;
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t        rx_state_q, rx_state_d;
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             frame_err_q, frame_err_d;

    // Receiver next-state: half-bit wait to the start centre, then one full
    // bit period between samples so every bit is taken near its centre
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rxd_fall) begin
                    rx_state_d = R_START;
                    rx_cnt_d   = '0;
                end else begin
                    rx_cnt_d   = '0;
                end
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    // A line already back high was a glitch, not a start bit
                    if (rxd_sync_q == 1'b0) begin
                        rx_state_d = R_DATA;
                    end else begin
                        rx_state_d = R_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            R_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_IDLE;
                    if (rxd_sync_q == 1'b1) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = rx_shift_q;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: begin
                rx_state_d = R_IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    // Receiver state registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_state_q   <= R_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ---------------- Frame decoder ----------------
    fr_state_t   fr_state_q, fr_state_d;
    logic [7:0]  addr_q, addr_d;
    logic [8:0]  remain_q, remain_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  lo_q, lo_d;
    logic [14:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        nreset_q, nreset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Frame next-state; the address advances the cycle after each write strobe
    always_comb begin
        fr_state_d = fr_state_q;
        remain_d   = remain_q;
        csum_d     = csum_q;
        lo_d       = lo_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        nreset_d   = nreset_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        if (we_q) begin
            addr_d = addr_q + 8'd1;
        end else begin
            addr_d = addr_q;
        end

        if (frame_err_q && (fr_state_q != F_SYNC)) begin
            fr_state_d = F_ERR;
        end else begin
            case (fr_state_q)
                F_SYNC: begin
                    if (byte_valid_q && (byte_data_q == SYNC_BYTE)) begin
                        err_d      = 1'b0;
                        nreset_d   = 1'b0;
                        busy_d     = 1'b1;
                        addr_d     = 8'd0;
                        fr_state_d = F_COUNT;
                    end else begin
                        fr_state_d = F_SYNC;
                    end
                end
                F_COUNT: begin
                    if (byte_valid_q) begin
                        // A zero count byte encodes a full 256-word image
                        remain_d   = (byte_data_q == 8'd0) ? 9'd256 : {1'b0, byte_data_q};
                        csum_d     = byte_data_q;
                        fr_state_d = F_LO;
                    end else begin
                        fr_state_d = F_COUNT;
                    end
                end
                F_LO: begin
                    if (byte_valid_q) begin
                        lo_d       = byte_data_q;
                        csum_d     = csum_q + byte_data_q;
                        fr_state_d = F_HI;
                    end else begin
                        fr_state_d = F_LO;
                    end
                end
                F_HI: begin
                    if (byte_valid_q) begin
                        csum_d = csum_q + byte_data_q;
                        // Instructions are 15 bits wide; bit 15 set is a corrupt word
                        if (byte_data_q[7]) begin
                            fr_state_d = F_ERR;
                        end else begin
                            wdata_d  = {byte_data_q[6:0], lo_q};
                            we_d     = 1'b1;
                            remain_d = remain_q - 9'd1;
                            if (remain_q == 9'd1) begin
                                fr_state_d = F_CSUM;
                            end else begin
                                fr_state_d = F_LO;
                            end
                        end
                    end else begin
                        fr_state_d = F_HI;
                    end
                end
                F_CSUM: begin
                    if (byte_valid_q) begin
                        if (byte_data_q == csum_q) begin
                            done_d     = 1'b1;
                            nreset_d   = 1'b1;
                            busy_d     = 1'b0;
                            fr_state_d = F_SYNC;
                        end else begin
                            fr_state_d = F_ERR;
                        end
                    end else begin
                        fr_state_d = F_CSUM;
                    end
                end
                F_ERR: begin
                    // Core stays in reset: memory may hold a partial image
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    nreset_d   = 1'b0;
                    fr_state_d = F_SYNC;
                end
                default: begin
                    fr_state_d = F_SYNC;
                end
            endcase
        end
    end

    // Frame state and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fr_state_q <= F_SYNC;
            addr_q     <= 8'd0;
            remain_q   <= 9'd0;
            csum_q     <= 8'd0;
            lo_q       <= 8'd0;
            wdata_q    <= 15'd0;
            we_q       <= 1'b0;
            nreset_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fr_state_q <= fr_state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            csum_q     <= csum_d;
            lo_q       <= lo_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            nreset_q   <= nreset_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rom.rom_we    = we_q;
    assign rom.rom_addr  = addr_q;
    assign rom.rom_wdata = wdata_q;
    assign cpu_nreset    = nreset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
